seg7_scan_driver: RTL and testbench

- Display-side consumer for the clock counters: accepts a binary count over a valid/ready handshake and converts it to four BCD digits with a sequential double-dabble engine.
- Drives a 4-digit multiplexed common-anode 7-segment display by time-division scanning.
- Sits between the time-keeping counters and the board display pins.

---
 rtl/seg7_scan_driver_if.sv | 19 +
 rtl/seg7_scan_driver.sv | 190 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Value handshake between the time-keeping counters (master) and the
// 7-segment scan driver (slave).
interface seg7_scan_driver_if;
    logic [13:0] value_in;
    logic        value_valid;
    logic        value_ready;

    modport master (
        output value_in,
        output value_valid,
        input  value_ready
    );

    modport slave (
        input  value_in,
        input  value_valid,
        output value_ready
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD conversion (sequential double dabble) feeding a 4-digit
// multiplexed common-anode 7-segment display with leading-zero blanking.
module seg7_scan_driver #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int SCAN_HZ  = 4_000,
    parameter int BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   vin,
    input  logic [3:0]          dp_in,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [3:0]          an
);

    localparam int DIGIT_DIV = CLK_FREQ / SCAN_HZ;
    localparam int PW        = (DIGIT_DIV > 2) ? $clog2(DIGIT_DIV) : 1;
    localparam logic [PW-1:0] TERM_CNT = PW'(DIGIT_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_UPDATE  = 2'd2
    } state_t;

    // Active-low gfedcba font; codes above 9 are unreachable and blank.
    function automatic logic [6:0] seg_font(input logic [3:0] code);
        logic [6:0] f;
        case (code)
            4'd0:    f = 7'b1000000;
            4'd1:    f = 7'b1111001;
            4'd2:    f = 7'b0100100;
            4'd3:    f = 7'b0110000;
            4'd4:    f = 7'b0011001;
            4'd5:    f = 7'b0010010;
            4'd6:    f = 7'b0000010;
            4'd7:    f = 7'b1111000;
            4'd8:    f = 7'b0000000;
            4'd9:    f = 7'b0010000;
            default: f = 7'h7F;
        endcase
        return f;
    endfunction

    // Double-dabble correction: each nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    state_t        state_r;
    logic [13:0]   bin_r;
    logic [15:0]   bcd_r;
    logic [3:0]    iter_r;
    logic [15:0]   disp_r;
    logic          ready_r;
    logic [29:0]   shift_s;
    logic [13:0]   sat_value_s;

    logic [PW-1:0] prescale_r;
    logic [1:0]    scan_idx_r;
    logic [6:0]    seg_r;
    logic          dp_r;
    logic [3:0]    an_r;

    logic [1:0]    next_idx_s;
    logic [3:0]    digit_s;
    logic          lead_blank_s;
    logic [3:0]    next_an_s;
    logic [6:0]    next_seg_s;
    logic          next_dp_s;

    // Conversion datapath: saturated input and one adjusted shift step.
    always_comb begin
        sat_value_s = vin.value_in;
        if (vin.value_in > 14'd9999) begin
            sat_value_s = 14'd9999;
        end else begin
            sat_value_s = vin.value_in;
        end
        shift_s = {dabble_adjust(bcd_r), bin_r};
    end

    // Handshake / conversion FSM; display register is written only on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            bin_r   <= 14'd0;
            bcd_r   <= 16'd0;
            iter_r  <= 4'd0;
            disp_r  <= 16'd0;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (vin.value_valid && ready_r) begin
                        bin_r   <= sat_value_s;
                        bcd_r   <= 16'd0;
                        iter_r  <= 4'd0;
                        ready_r <= 1'b0;
                        state_r <= ST_CONVERT;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    bcd_r  <= shift_s[28:13];
                    bin_r  <= {shift_s[12:0], 1'b0};
                    iter_r <= iter_r + 4'd1;
                    if (iter_r == 4'd13) begin
                        state_r <= ST_UPDATE;
                    end else begin
                        state_r <= ST_CONVERT;
                    end
                end
                ST_UPDATE: begin
                    disp_r  <= bcd_r;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign vin.value_ready = ready_r;

    // Next-digit selection, font lookup and leading-zero blanking.
    always_comb begin
        next_idx_s   = scan_idx_r + 2'd1;
        digit_s      = 4'd0;
        lead_blank_s = 1'b0;
        case (next_idx_s)
            2'd0:    digit_s = disp_r[3:0];
            2'd1:    digit_s = disp_r[7:4];
            2'd2:    digit_s = disp_r[11:8];
            2'd3:    digit_s = disp_r[15:12];
            default: digit_s = 4'd0;
        endcase
        if (BLANK_LZ != 0) begin
            case (next_idx_s)
                2'd1:    lead_blank_s = (disp_r[15:4]  == 12'd0);
                2'd2:    lead_blank_s = (disp_r[15:8]  == 8'd0);
                2'd3:    lead_blank_s = (disp_r[15:12] == 4'd0);
                default: lead_blank_s = 1'b0;
            endcase
        end else begin
            lead_blank_s = 1'b0;
        end
        next_an_s  = ~(4'b0001 << next_idx_s);
        next_seg_s = lead_blank_s ? 7'h7F : seg_font(digit_s);
        next_dp_s  = ~dp_in[next_idx_s];
    end

    // Scan prescaler; display outputs only change on the terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale_r <= {PW{1'b0}};
            scan_idx_r <= 2'd3;
            seg_r      <= 7'h7F;
            dp_r       <= 1'b1;
            an_r       <= 4'hF;
        end else if (prescale_r == TERM_CNT) begin
            prescale_r <= {PW{1'b0}};
            scan_idx_r <= next_idx_s;
            an_r       <= next_an_s;
            seg_r      <= next_seg_s;
            dp_r       <= next_dp_s;
        end else begin
            prescale_r <= prescale_r + PW'(1);
        end
    end

    assign seg = seg_r;
    assign dp  = dp_r;
    assign an  = an_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: two instances (blanking on / off) share one stimulus stream.
module tb_seg7_scan_driver;

    localparam logic [6:0] F0 = 7'b1000000;
    localparam logic [6:0] F1 = 7'b1111001;
    localparam logic [6:0] F2 = 7'b0100100;
    localparam logic [6:0] F3 = 7'b0110000;
    localparam logic [6:0] F4 = 7'b0011001;
    localparam logic [6:0] F7 = 7'b1111000;
    localparam logic [6:0] F9 = 7'b0010000;
    localparam logic [6:0] BL = 7'h7F;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] dp_in = 4'd0;
    logic [6:0] seg_lz, seg_nz;
    logic       dp_lz, dp_nz;
    logic [3:0] an_lz, an_nz;
    int vectors = 0;
    int miscompares = 0;

    seg7_scan_driver_if if_lz ();
    seg7_scan_driver_if if_nz ();

    seg7_scan_driver #(.CLK_FREQ(40), .SCAN_HZ(4), .BLANK_LZ(1)) dut_lz (
        .clk(clk), .rst(rst), .vin(if_lz), .dp_in(dp_in),
        .seg(seg_lz), .dp(dp_lz), .an(an_lz)
    );
    seg7_scan_driver #(.CLK_FREQ(40), .SCAN_HZ(4), .BLANK_LZ(0)) dut_nz (
        .clk(clk), .rst(rst), .vin(if_nz), .dp_in(dp_in),
        .seg(seg_nz), .dp(dp_nz), .an(an_nz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [13:0] v, input logic vld);
        if_lz.value_in = v; if_lz.value_valid = vld;
        if_nz.value_in = v; if_nz.value_valid = vld;
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        chk({tag, " ready_lz"}, {31'd0, if_lz.value_ready}, {31'd0, exp});
        chk({tag, " ready_nz"}, {31'd0, if_nz.value_ready}, {31'd0, exp});
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " an"},  {28'd0, an_lz},  32'hF);
        chk({tag, " seg"}, {25'd0, seg_lz}, 32'h7F);
        chk({tag, " dp"},  {31'd0, dp_lz},  32'd1);
        chk({tag, " an_nz"},  {28'd0, an_nz},  32'hF);
        chk({tag, " seg_nz"}, {25'd0, seg_nz}, 32'h7F);
        chk_ready(tag, 1'b1);
    endtask

    // Waits (bounded) for the anode pattern to move to the next digit.
    task automatic next_tick(input string tag);
        logic [3:0] prev;
        int n;
        prev = an_lz;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an_lz === prev && n < 12);
        chk({tag, " tick"}, {31'd0, (an_lz !== prev)}, 32'd1);
    endtask

    // Checks one full scan frame from digit 0 through digit 3.
    task automatic check_frame(input string tag, input logic [27:0] exp_lz, input logic [27:0] exp_nz);
        logic [3:0] e_an;
        logic       e_dp;
        int k;
        k = 0;
        next_tick(tag);
        while (an_lz !== 4'b1110 && k < 4) begin
            next_tick(tag);
            k++;
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_tick(tag);
            e_an = ~(4'b0001 << i);
            e_dp = ~dp_in[i];
            chk($sformatf("%s an d%0d", tag, i),     {28'd0, an_lz},  {28'd0, e_an});
            chk($sformatf("%s an_nz d%0d", tag, i),  {28'd0, an_nz},  {28'd0, e_an});
            chk($sformatf("%s seg d%0d", tag, i),    {25'd0, seg_lz}, {25'd0, exp_lz[7*i +: 7]});
            chk($sformatf("%s seg_nz d%0d", tag, i), {25'd0, seg_nz}, {25'd0, exp_nz[7*i +: 7]});
            chk($sformatf("%s dp d%0d", tag, i),     {31'd0, dp_lz},  {31'd0, e_dp});
        end
    endtask

    // One-cycle handshake followed by the 15-cycle busy window.
    task automatic send(input string tag, input logic [13:0] v);
        chk_ready({tag, " pre"}, 1'b1);
        drive(v, 1'b1);
        @(negedge clk);
        drive(v, 1'b0);
        chk_ready({tag, " busy"}, 1'b0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk_ready({tag, " busy"}, 1'b0);
        end
        @(negedge clk);
        chk_ready({tag, " done"}, 1'b1);
    endtask

    initial begin
        drive(14'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");

        // Release: digit 0 appears on the 10th edge, then each digit lasts 10 cycles.
        rst = 1'b1;
        repeat (9) @(negedge clk);
        chk("pre-tick an", {28'd0, an_lz}, 32'hF);
        @(negedge clk);
        chk("tick0 an", {28'd0, an_lz}, 32'hE);
        chk("tick0 seg", {25'd0, seg_lz}, {25'd0, F0});
        chk("tick0 seg_nz", {25'd0, seg_nz}, {25'd0, F0});
        repeat (9) @(negedge clk);
        chk("tick0 hold an", {28'd0, an_lz}, 32'hE);
        @(negedge clk);
        chk("tick1 an", {28'd0, an_lz}, 32'hD);
        chk("tick1 seg", {25'd0, seg_lz}, {25'd0, BL});
        chk("tick1 seg_nz", {25'd0, seg_nz}, {25'd0, F0});
        check_frame("idle", {BL, BL, BL, F0}, {F0, F0, F0, F0});

        dp_in = 4'b0101;
        send("v1234", 14'd1234);
        check_frame("v1234", {F1, F2, F3, F4}, {F1, F2, F3, F4});

        dp_in = 4'b0000;
        send("v16000", 14'd16000);
        check_frame("v16000", {F9, F9, F9, F9}, {F9, F9, F9, F9});

        dp_in = 4'b1000;
        send("v7", 14'd7);
        check_frame("v7", {BL, BL, BL, F7}, {F0, F0, F0, F7});

        // 42 accepted, 99 held valid throughout and taken one cycle after ready returns.
        dp_in = 4'b0000;
        chk_ready("v42 pre", 1'b1);
        drive(14'd42, 1'b1);
        @(negedge clk);
        drive(14'd99, 1'b1);
        chk_ready("v42 busy", 1'b0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk_ready("v42 busy", 1'b0);
        end
        @(negedge clk);
        chk_ready("v42 done", 1'b1);
        @(negedge clk);
        chk_ready("v99 accept", 1'b0);
        drive(14'd99, 1'b0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk_ready("v99 busy", 1'b0);
        end
        @(negedge clk);
        chk_ready("v99 done", 1'b1);
        check_frame("v99", {BL, BL, F9, F9}, {F0, F0, F9, F9});

        // Reset at E7 of a 5678 conversion with 1234 on display.
        send("r1234", 14'd1234);
        check_frame("r1234", {F1, F2, F3, F4}, {F1, F2, F3, F4});
        drive(14'd5678, 1'b1);
        @(posedge clk);
        #1 drive(14'd5678, 1'b0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk_reset_outs("abort");
        @(negedge clk);
        rst = 1'b1;
        repeat (9) @(negedge clk);
        chk("abort pre-tick an", {28'd0, an_lz}, 32'hF);
        chk_ready("abort idle", 1'b1);
        @(negedge clk);
        chk("abort tick0 an", {28'd0, an_lz}, 32'hE);
        chk("abort tick0 seg", {25'd0, seg_lz}, {25'd0, F0});
        check_frame("abort", {BL, BL, BL, F0}, {F0, F0, F0, F0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
